// File: rtl/mempy_arbiter.sv
// Round-robin front end that shares one mempy lookup-table multiplier among R requesters.
// One operation is in flight at a time; the product returns on a ready/valid response channel.
module mempy_arbiter #(
    parameter int N        = 2,
    parameter int R        = 4,
    parameter int READ_LAT = 1,
    parameter int IDW      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req,
    input  logic [R*N-1:0]   a_in,
    input  logic [R*N-1:0]   b_in,
    output logic [R-1:0]     gnt,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [2*N-1:0]   rsp_data,
    input  logic             rsp_ready,
    output logic [2*N-1:0]   mem_address,
    output logic             mem_read_en,
    output logic             mem_ce,
    input  logic [2*N-1:0]   mem_data,
    output logic [1:0]       dbg_state_o
);
    localparam int W  = 2 * N;
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [R-1:0]     gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic [W-1:0]     addr_q, addr_d;
    logic             mem_en_q, mem_en_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [IDW-1:0]   rr_q, rr_d;

    logic [N-1:0]     a_arr [R];
    logic [N-1:0]     b_arr [R];
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   idx;

    always_comb begin
        for (int i = 0; i < R; i++) begin
            a_arr[i] = a_in[i*N +: N];
            b_arr[i] = b_in[i*N +: N];
        end
    end

    // Scan from the farthest offset down so the nearest requester at or after rr_q wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int j = R - 1; j >= 0; j--) begin
            idx = IDW'((int'(rr_q) + j) % R);
            if (req[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        addr_d      = addr_q;
        mem_en_d    = mem_en_q;
        lat_d       = lat_q;
        rr_d        = rr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d[pick] = 1'b1;
                    addr_d      = {a_arr[pick], b_arr[pick]};
                    mem_en_d    = 1'b1;
                    rsp_id_d    = pick;
                    rr_d        = IDW'((int'(pick) + 1) % R);
                    lat_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_q == LW'(READ_LAT - 1)) begin
                    rsp_data_d  = mem_data;
                    rsp_valid_d = 1'b1;
                    mem_en_d    = 1'b0;
                    addr_d      = '0;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            RESP: begin
                // Returning to IDLE here means the next grant comes one edge later.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            mem_en_q    <= 1'b0;
            lat_q       <= '0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            addr_q      <= addr_d;
            mem_en_q    <= mem_en_d;
            lat_q       <= lat_d;
            rr_q        <= rr_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign mem_address = addr_q;
    assign mem_read_en = mem_en_q;
    assign mem_ce      = mem_en_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mempy_arbiter.sv
// Directed bench for mempy_arbiter: a behavioural mempy table feeds two instances
// (READ_LAT=1 and READ_LAT=3); grants and responses are checked against expected queues.
module tb_mempy_arbiter;
    localparam int N   = 2;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int W   = 2 * N;

    logic           clk;
    logic           rst_n;
    logic [R-1:0]   req;
    logic [R*N-1:0] a_in, b_in;
    logic [R-1:0]   gnt;
    logic           rsp_valid, rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data, mem_address, mem_data;
    logic           mem_read_en, mem_ce;
    logic [1:0]     dbg_state;

    logic [R-1:0]   r3_req;
    logic [R*N-1:0] r3_a, r3_b;
    logic [R-1:0]   r3_gnt;
    logic           r3_valid, r3_ready;
    logic [IDW-1:0] r3_id;
    logic [W-1:0]   r3_data, r3_addr, r3_mdata;
    logic           r3_re, r3_ce;
    logic [1:0]     r3_state;

    logic [R-1:0]       gnt_q [$];
    logic [IDW+W-1:0]   rsp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Behavioural mempy: asynchronous table read of a*b while enabled.
    assign mem_data = (mem_ce && mem_read_en) ?
                      W'(mem_address[W-1:N]) * W'(mem_address[N-1:0]) : '0;
    assign r3_mdata = (r3_ce && r3_re) ? W'(r3_addr[W-1:N]) * W'(r3_addr[N-1:0]) : '0;

    mempy_arbiter #(.N(N), .R(R), .READ_LAT(1), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_ce(mem_ce),
        .mem_data(mem_data), .dbg_state_o(dbg_state)
    );

    mempy_arbiter #(.N(N), .R(R), .READ_LAT(3), .IDW(IDW)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(r3_req), .a_in(r3_a), .b_in(r3_b), .gnt(r3_gnt),
        .rsp_valid(r3_valid), .rsp_id(r3_id), .rsp_data(r3_data), .rsp_ready(r3_ready),
        .mem_address(r3_addr), .mem_read_en(r3_re), .mem_ce(r3_ce),
        .mem_data(r3_mdata), .dbg_state_o(r3_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: grants and accepted responses must match the expected queues in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
                else chk("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 32'({rsp_id, rsp_data}), 0);
                else chk("rsp_id_data", 32'({rsp_id, rsp_data}), 32'(rsp_q.pop_front()));
            end
        end
    end

    task automatic wait_any_gnt();
        int t;
        for (t = 0; t < 30; t++) begin
            @(negedge clk);
            if (gnt != '0) break;
        end
        chk("gnt_wait_timeout", 32'(t < 30), 1);
    endtask

    task automatic wait_drain();
        int t;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            #1;
            if (rsp_q.size() == 0) break;
        end
        chk("drain_timeout", 32'(t < 40), 1);
    endtask

    task automatic do_op(input int i, input int a, input int b);
        a_in[i*N +: N] = N'(a);
        b_in[i*N +: N] = N'(b);
        gnt_q.push_back(R'(1 << i));
        rsp_q.push_back({IDW'(i), W'(a * b)});
        req[i] = 1'b1;
        wait_any_gnt();
        @(posedge clk);
        #1 req[i] = 1'b0;
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int last;
        int t;
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1;
        r3_req = '0; r3_a = '0; r3_b = '0; r3_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_mem_ce", 32'(mem_ce), 0);
        chk("rst_mem_read_en", 32'(mem_read_en), 0);
        chk("rst_state", 32'(dbg_state), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All requesters active from reset: grants rotate 0,1,2,3,0 every READ_LAT+2 cycles.
        for (int i = 0; i < R; i++) begin
            a_in[i*N +: N] = N'((i + 1) % 4);
            b_in[i*N +: N] = N'(3);
        end
        for (int g = 0; g < 5; g++) begin
            gnt_q.push_back(R'(1 << (g % R)));
            rsp_q.push_back({IDW'(g % R), W'(((g % R + 1) % 4) * 3)});
        end
        req = '1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_any_gnt();
            if (g > 0) chk("grant_interval", 32'(cyc - last), 3);
            last = cyc;
        end
        @(posedge clk);
        #1 req = '0;
        wait_drain();
        @(posedge clk);
        #1;

        // Basic single operation on requester 0: address {3,2}, product 6.
        a_in[0 +: N] = 2'd3; b_in[0 +: N] = 2'd2;
        gnt_q.push_back(4'b0001);
        rsp_q.push_back({2'd0, 4'd6});
        req[0] = 1'b1;
        wait_any_gnt();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_addr", 32'(mem_address), 32'hE);
        chk("t1_ce", 32'({mem_ce, mem_read_en}), 32'h3);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 1);
        chk("t1_ce_off", 32'(mem_ce), 0);
        wait_drain();
        @(posedge clk);
        #1;

        // Backpressure on requester 1 (3*3) with requester 3 waiting.
        rsp_ready = 1'b0;
        a_in[1*N +: N] = 2'd3; b_in[1*N +: N] = 2'd3;
        gnt_q.push_back(4'b0010);
        rsp_q.push_back({2'd1, 4'd9});
        req[1] = 1'b1;
        wait_any_gnt();
        @(posedge clk);
        #1 req[1] = 1'b0;
        a_in[3*N +: N] = 2'd2; b_in[3*N +: N] = 2'd2;
        gnt_q.push_back(4'b1000);
        rsp_q.push_back({2'd3, 4'd4});
        req[3] = 1'b1;
        for (t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("bp_valid_timeout", 32'(t < 10), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_data", 32'(rsp_data), 9);
            chk("bp_ce_low", 32'(mem_ce), 0);
            chk("bp_no_gnt", 32'(gnt), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_accept_no_gnt", 32'(gnt), 0);
        @(negedge clk);
        chk("bp_next_gnt", 32'(gnt), 32'h8);
        @(posedge clk);
        #1 req[3] = 1'b0;
        wait_drain();
        @(posedge clk);
        #1;

        // Exhaustive operand sweep on requester 2, including all-ones.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                do_op(2, a, b);

        // A request withdrawn before it can be granted must leave no trace.
        a_in[0 +: N] = 2'd1; b_in[0 +: N] = 2'd1;
        gnt_q.push_back(4'b0001);
        rsp_q.push_back({2'd0, 4'd1});
        req[0] = 1'b1;
        wait_any_gnt();
        @(posedge clk);
        #1 req[0] = 1'b0; req[1] = 1'b1;
        @(posedge clk);
        #1 req[1] = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("drop_no_gnt", 32'(gnt), 0);

        // READ_LAT=3 instance: enables held 3 cycles with a stable address.
        @(posedge clk);
        #1;
        r3_a[1*N +: N] = 2'd3; r3_b[1*N +: N] = 2'd2;
        r3_req = 4'b0010;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (r3_gnt != '0) break;
        end
        chk("l3_gnt_timeout", 32'(t < 20), 1);
        chk("l3_gnt", 32'(r3_gnt), 32'h2);
        chk("l3_ce_c0", 32'({r3_ce, r3_re}), 32'h3);
        chk("l3_addr_c0", 32'(r3_addr), 32'hE);
        @(posedge clk);
        #1 r3_req = '0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk("l3_ce_held", 32'({r3_ce, r3_re}), 32'h3);
            chk("l3_addr_held", 32'(r3_addr), 32'hE);
            chk("l3_not_valid", 32'(r3_valid), 0);
        end
        @(negedge clk);
        chk("l3_ce_off", 32'(r3_ce), 0);
        chk("l3_valid", 32'(r3_valid), 1);
        chk("l3_data", 32'(r3_data), 6);
        chk("l3_id", 32'(r3_id), 1);
        @(negedge clk);
        chk("l3_valid_clear", 32'(r3_valid), 0);

        // Reset pulsed mid-ACCESS discards the in-flight operation.
        @(posedge clk);
        #1;
        a_in[1*N +: N] = 2'd2; b_in[1*N +: N] = 2'd2;
        gnt_q.push_back(4'b0010);
        req[1] = 1'b1;
        wait_any_gnt();
        chk("rst_mid_state", 32'(dbg_state), 1);
        #1 rst_n = 1'b0;
        req = '0;
        #1;
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_ce", 32'({mem_ce, mem_read_en}), 0);
        chk("rst_mid_addr", 32'(mem_address), 0);
        chk("rst_mid_id", 32'(rsp_id), 0);
        chk("rst_mid_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        do_op(2, 1, 2);

        chk("gnt_q_empty", 32'(gnt_q.size()), 0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
